fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_ifid_reg.sv | 58 +++++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: data width, NOP encoding, FSM states.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register: load captures a new entry, flush drops the valid bit.
module fetch_ifid_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  // A flush only clears valid; the payload is left as-is so it reads stable.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
    end else if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control, redirect handling, IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 256,
  parameter int              ADDR_W   = $clog2(DEPTH),
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]   imem_rd,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt_req,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_instr,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_pc_plus4,
  output logic              fetch_misalign,
  output logic [XLEN-1:0]   fetch_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            advance;
  logic            redirect_take;
  logic            redirect_aligned;
  logic            flush;
  logic [XLEN-1:0] pc_plus4;

  assign pc_plus4         = pc_q + 32'd4;
  assign redirect_take    = redirect_valid && (state_q != ST_BOOT);
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
  assign advance          = (state_q == ST_RUN) && !redirect_valid && (!id_valid || id_ready);
  // Drop the entry on a redirect, or when decode consumes it and nothing replaces it.
  assign flush            = redirect_take || (id_valid && id_ready && !advance);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (advance) begin
      pc_d    = pc_plus4;
      count_d = count_q + 32'd1;
    end
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_HALT: begin
        if (redirect_take) begin
          if (redirect_aligned) begin
            pc_d    = redirect_pc;
            state_d = halt_req ? ST_HALT : ST_RUN;
          end else begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end
        end else if (state_q == ST_RUN && halt_req) begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  fetch_ifid_reg u_ifid (
    .clk         (clk),
    .rst         (rst),
    .load        (advance),
    .flush       (flush),
    .instr_in    (imem_rd),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_plus4),
    .valid       (id_valid),
    .instr       (id_instr),
    .pc          (id_pc),
    .pc_plus4    (id_pc_plus4)
  );

  assign imem_addr      = pc_q[ADDR_W+1:2];
  assign fetch_misalign = misalign_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;
  logic        clk;
  logic        rst;
  logic [7:0]  imemAddr;
  logic [31:0] imemRd;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        haltReq;
  logic        idReady;
  logic        idValid;
  logic [31:0] idInstr;
  logic [31:0] idPc;
  logic [31:0] idPcPlus4;
  logic        fetchMisalign;
  logic [31:0] fetchCount;

  logic [31:0] mem [256];
  int checkCount = 0;
  int errorCount = 0;

  fetch_stage #(.DEPTH(256), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imemAddr),
    .imem_rd        (imemRd),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .halt_req       (haltReq),
    .id_ready       (idReady),
    .id_valid       (idValid),
    .id_instr       (idInstr),
    .id_pc          (idPc),
    .id_pc_plus4    (idPcPlus4),
    .fetch_misalign (fetchMisalign),
    .fetch_count    (fetchCount)
  );

  assign imemRd = mem[imemAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkEntry(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    checkOutput({tag, "_valid"}, {31'd0, idValid}, 32'd1);
    checkOutput({tag, "_pc"}, idPc, pc);
    checkOutput({tag, "_instr"}, idInstr, instr);
    checkOutput({tag, "_pc4"}, idPcPlus4, pc + 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h0070_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0010_0193;

    rst = 1'b1; idReady = 1'b1; redirectValid = 1'b0; redirectPc = '0; haltReq = 1'b0;
    applyStimulus(2);
    checkOutput("rst_valid", {31'd0, idValid}, 32'd0);
    checkOutput("rst_instr", idInstr, 32'h0000_0013);
    checkOutput("rst_pc", idPc, 32'd0);
    checkOutput("rst_pc4", idPcPlus4, 32'd0);
    checkOutput("rst_misalign", {31'd0, fetchMisalign}, 32'd0);
    checkOutput("rst_count", fetchCount, 32'd0);
    checkOutput("rst_addr", {24'd0, imemAddr}, 32'd0);

    // Straight-line fetch after reset release
    rst = 1'b0;
    applyStimulus(1);
    checkOutput("boot_valid", {31'd0, idValid}, 32'd0);
    applyStimulus(1);
    checkEntry("seq0", 32'h0, 32'h0070_0093);
    applyStimulus(1);
    checkEntry("seq1", 32'h4, 32'h0010_0113);
    applyStimulus(1);
    checkEntry("seq2", 32'h8, 32'h0010_0193);
    checkOutput("seq_count", fetchCount, 32'd3);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    checkOutput("async_valid", {31'd0, idValid}, 32'd0);
    checkOutput("async_count", fetchCount, 32'd0);
    checkOutput("async_addr", {24'd0, imemAddr}, 32'd0);
    applyStimulus(1);
    rst = 1'b0;

    // Decode stall holds the entry
    applyStimulus(3);
    checkEntry("pre_stall", 32'h4, 32'h0010_0113);
    idReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkEntry("stall", 32'h4, 32'h0010_0113);
      checkOutput("stall_addr", {24'd0, imemAddr}, 32'd2);
      checkOutput("stall_count", fetchCount, 32'd2);
    end
    idReady = 1'b1;
    applyStimulus(1);
    checkEntry("unstall", 32'h8, 32'h0010_0193);

    // Redirect flushes a stalled entry
    idReady = 1'b0; redirectValid = 1'b1; redirectPc = 32'h18;
    applyStimulus(1);
    checkOutput("redir_valid", {31'd0, idValid}, 32'd0);
    checkOutput("redir_addr", {24'd0, imemAddr}, 32'd6);
    redirectValid = 1'b0; idReady = 1'b1;
    applyStimulus(1);
    checkEntry("redir_tgt", 32'h18, 32'hC0DE_0006);
    checkOutput("redir_count", fetchCount, 32'd4);

    // Misaligned redirect halts and sets the sticky flag
    redirectValid = 1'b1; redirectPc = 32'h1A;
    applyStimulus(1);
    checkOutput("mis_flag", {31'd0, fetchMisalign}, 32'd1);
    checkOutput("mis_valid", {31'd0, idValid}, 32'd0);
    checkOutput("mis_addr", {24'd0, imemAddr}, 32'd7);
    redirectValid = 1'b0;
    applyStimulus(2);
    checkOutput("halt_valid", {31'd0, idValid}, 32'd0);
    checkOutput("halt_addr", {24'd0, imemAddr}, 32'd7);
    checkOutput("halt_count", fetchCount, 32'd4);
    redirectValid = 1'b1; redirectPc = 32'h0;
    applyStimulus(1);
    checkOutput("resume_addr", {24'd0, imemAddr}, 32'd0);
    redirectValid = 1'b0;
    applyStimulus(1);
    checkEntry("resume", 32'h0, 32'h0070_0093);
    checkOutput("resume_flag", {31'd0, fetchMisalign}, 32'd1);

    // halt_req at pc=0x10: that fetch still lands, nothing after it
    applyStimulus(3);
    checkEntry("pre_halt", 32'hC, 32'hC0DE_0003);
    haltReq = 1'b1;
    applyStimulus(1);
    checkEntry("halt_cap", 32'h10, 32'hC0DE_0004);
    haltReq = 1'b0;
    applyStimulus(2);
    checkOutput("halted_valid", {31'd0, idValid}, 32'd0);
    checkOutput("halted_addr", {24'd0, imemAddr}, 32'd5);
    checkOutput("halted_count", fetchCount, 32'd9);
    redirectValid = 1'b1; redirectPc = 32'h2C;
    applyStimulus(1);
    redirectValid = 1'b0;
    applyStimulus(1);
    checkEntry("rehalt_tgt", 32'h2C, 32'hC0DE_000B);
    checkOutput("rehalt_count", fetchCount, 32'd10);

    // Memory index wraps from DEPTH-1 to 0
    redirectValid = 1'b1; redirectPc = 32'h3FC;
    applyStimulus(1);
    checkOutput("wrap_addr_hi", {24'd0, imemAddr}, 32'd255);
    redirectValid = 1'b0;
    applyStimulus(1);
    checkEntry("wrap_a", 32'h3FC, 32'hC0DE_00FF);
    checkOutput("wrap_addr_lo", {24'd0, imemAddr}, 32'd0);
    applyStimulus(1);
    checkEntry("wrap_b", 32'h400, 32'h0070_0093);
    checkOutput("wrap_count", fetchCount, 32'd12);

    // PC wraps modulo 2^32
    redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFC;
    applyStimulus(1);
    redirectValid = 1'b0;
    applyStimulus(1);
    checkEntry("pcwrap", 32'hFFFF_FFFC, 32'hC0DE_00FF);
    checkOutput("pcwrap_pc4", idPcPlus4, 32'h0);
    checkOutput("pcwrap_addr", {24'd0, imemAddr}, 32'd0);

    // Aligned redirect with halt_req lands in HALT
    redirectValid = 1'b1; redirectPc = 32'h20; haltReq = 1'b1;
    applyStimulus(1);
    redirectValid = 1'b0; haltReq = 1'b0;
    applyStimulus(2);
    checkOutput("rhalt_valid", {31'd0, idValid}, 32'd0);
    checkOutput("rhalt_addr", {24'd0, imemAddr}, 32'd8);
    checkOutput("rhalt_count", fetchCount, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
